dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous data memory (dmem, 12-bit word address, 32-bit data) between the processor and a secondary requester (program loader / debug reader). The processor has fixed priority. A saturating starvation counter guarantees the secondary port a slot after a bounded wait. The block sits between the processor's dmem outputs and the dmem instance, and returns read data, tagged by owner, one cycle after issue.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/grant/return signals between requesters, arbiter and dmem
// master: requesters plus dmem q; slave: the arbiter itself.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              p0_req;
   logic              p0_wren;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_data;
   logic              p0_gnt;
   logic              p0_valid;
   logic [DATA_W-1:0] p0_q;

   logic              p1_req;
   logic              p1_wren;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_data;
   logic              p1_gnt;
   logic              p1_valid;
   logic [DATA_W-1:0] p1_q;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;

   modport slave (
      input  p0_req, p0_wren, p0_addr, p0_data,
      input  p1_req, p1_wren, p1_addr, p1_data,
      input  mem_q,
      output p0_gnt, p0_valid, p0_q,
      output p1_gnt, p1_valid, p1_q,
      output mem_address, mem_data, mem_wren
   );

   modport master (
      output p0_req, p0_wren, p0_addr, p0_data,
      output p1_req, p1_wren, p1_addr, p1_data,
      output mem_q,
      input  p0_gnt, p0_valid, p0_q,
      input  p1_gnt, p1_valid, p1_q,
      input  mem_address, mem_data, mem_wren
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - fixed-priority dmem arbiter with starvation bound and tagged read return
// p0 has priority; p1 is forced through after MAX_WAIT consecutive denied cycles.
module dmem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic clock,
   input  logic reset,
   dmem_arbiter_if.slave bus
);
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_P0,
      OWN_P1
   } owner_t;

   owner_t     rd_owner;
   owner_t     rd_owner_next;
   logic [3:0] starve;
   logic [3:0] starve_next;
   logic       p0_win;
   logic       p1_win;

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_owner <= OWN_NONE;
         starve   <= 4'd0;
      end else begin
         rd_owner <= rd_owner_next;
         starve   <= starve_next;
      end
   end

   always_comb begin
      p1_win          = 1'b0;
      p0_win          = 1'b0;
      starve_next     = 4'd0;
      rd_owner_next   = OWN_NONE;
      bus.p0_gnt      = 1'b0;
      bus.p1_gnt      = 1'b0;
      bus.mem_address = '0;
      bus.mem_data    = '0;
      bus.mem_wren    = 1'b0;
      bus.p0_valid    = 1'b0;
      bus.p0_q        = '0;
      bus.p1_valid    = 1'b0;
      bus.p1_q        = '0;

      // Grants are suppressed while reset is high so nothing is issued to dmem.
      p1_win = !reset && bus.p1_req && (!bus.p0_req || starve == MAX_WAIT_C);
      p0_win = !reset && bus.p0_req && !p1_win;

      bus.p0_gnt = p0_win;
      bus.p1_gnt = p1_win;

      if (p1_win) begin
         bus.mem_address = bus.p1_addr;
         bus.mem_data    = bus.p1_data;
         bus.mem_wren    = bus.p1_wren;
         if (!bus.p1_wren) rd_owner_next = OWN_P1;
      end else if (p0_win) begin
         bus.mem_address = bus.p0_addr;
         bus.mem_data    = bus.p0_data;
         bus.mem_wren    = bus.p0_wren;
         if (!bus.p0_wren) rd_owner_next = OWN_P0;
      end

      // Waiting only accumulates while p1 keeps asking; any gap forfeits the credit.
      if (bus.p1_req && !p1_win)
         starve_next = (starve == MAX_WAIT_C) ? starve : starve + 4'd1;

      // Gating with reset hides a return whose grant preceded reset.
      if (!reset && rd_owner == OWN_P0) begin
         bus.p0_valid = 1'b1;
         bus.p0_q     = bus.mem_q;
      end
      if (!reset && rd_owner == OWN_P1) begin
         bus.p1_valid = 1'b1;
         bus.p1_q     = bus.mem_q;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed-vector bench for dmem_arbiter with a write-first dmem model
module tb_dmem_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Synchronous single-port dmem, write-first.
   logic [31:0] mem_arr [0:4095];
   logic [31:0] mem_q_r = 32'd0;
   always @(posedge clock) begin
      if (bus.mem_wren) begin
         mem_arr[bus.mem_address] <= bus.mem_data;
         mem_q_r                  <= bus.mem_data;
      end else begin
         mem_q_r <= mem_arr[bus.mem_address];
      end
   end
   assign bus.mem_q = mem_q_r;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic drive0(input logic req, input logic wren, input logic [11:0] addr, input logic [31:0] data);
      bus.p0_req = req; bus.p0_wren = wren; bus.p0_addr = addr; bus.p0_data = data;
   endtask

   task automatic drive1(input logic req, input logic wren, input logic [11:0] addr, input logic [31:0] data);
      bus.p1_req = req; bus.p1_wren = wren; bus.p1_addr = addr; bus.p1_data = data;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_gnt"}, {30'd0, bus.p0_gnt, bus.p1_gnt}, 32'd0);
      check({tag, "_valid"}, {30'd0, bus.p0_valid, bus.p1_valid}, 32'd0);
      check({tag, "_q0"}, bus.p0_q, 32'd0);
      check({tag, "_q1"}, bus.p1_q, 32'd0);
      check({tag, "_mem"}, {19'd0, bus.mem_wren, bus.mem_address}, 32'd0);
      check({tag, "_mdata"}, bus.mem_data, 32'd0);
   endtask

   initial begin
      drive0(1'b0, 1'b0, 12'h000, 32'd0);
      drive1(1'b0, 1'b0, 12'h000, 32'd0);
      reset = 1'b1;
      next_cycle();
      drive0(1'b1, 1'b0, 12'h010, 32'd0);
      drive1(1'b1, 1'b0, 12'h020, 32'd0);
      @(negedge clock);
      check_quiet("reset_req_high");
      next_cycle();
      drive0(1'b0, 1'b0, 12'h000, 32'd0);
      drive1(1'b0, 1'b0, 12'h000, 32'd0);
      next_cycle();
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check_quiet("idle");
         next_cycle();
      end

      // p0 write then read of 0x010
      drive0(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
      @(negedge clock);
      check("wr_p0_gnt", {31'd0, bus.p0_gnt}, 32'd1);
      check("wr_mem", {19'd0, bus.mem_wren, bus.mem_address}, {19'd0, 1'b1, 12'h010});
      check("wr_mdata", bus.mem_data, 32'hDEADBEEF);
      next_cycle();
      drive0(1'b1, 1'b0, 12'h010, 32'd0);
      @(negedge clock);
      check("rd_p0_gnt", {31'd0, bus.p0_gnt}, 32'd1);
      check("rd_mem_wren", {31'd0, bus.mem_wren}, 32'd0);
      check("wr_no_valid", {30'd0, bus.p0_valid, bus.p1_valid}, 32'd0);
      next_cycle();
      drive0(1'b0, 1'b0, 12'h000, 32'd0);
      @(negedge clock);
      check("rd_p0_valid", {30'd0, bus.p0_valid, bus.p1_valid}, 32'd2);
      check("rd_p0_q", bus.p0_q, 32'hDEADBEEF);
      check("rd_p1_q", bus.p1_q, 32'd0);
      next_cycle();

      // Preload: p0 writes 0x001, then p1 alone writes 0x002
      drive0(1'b1, 1'b1, 12'h001, 32'h11);
      next_cycle();
      drive0(1'b0, 1'b0, 12'h000, 32'd0);
      drive1(1'b1, 1'b1, 12'h002, 32'h22);
      @(negedge clock);
      check("p1_wr_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, 32'd1);
      check("p1_wr_mem", {19'd0, bus.mem_wren, bus.mem_address}, {19'd0, 1'b1, 12'h002});
      check("p1_wr_mdata", bus.mem_data, 32'h22);
      next_cycle();
      drive1(1'b0, 1'b0, 12'h000, 32'd0);
      next_cycle();

      // Alternating reads routed by owner
      drive0(1'b1, 1'b0, 12'h001, 32'd0);
      @(negedge clock);
      check("alt_n_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, 32'd2);
      next_cycle();
      drive0(1'b0, 1'b0, 12'h000, 32'd0);
      drive1(1'b1, 1'b0, 12'h002, 32'd0);
      @(negedge clock);
      check("alt_n1_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, 32'd1);
      check("alt_n1_valid", {30'd0, bus.p0_valid, bus.p1_valid}, 32'd2);
      check("alt_n1_q0", bus.p0_q, 32'h11);
      next_cycle();
      drive1(1'b0, 1'b0, 12'h000, 32'd0);
      @(negedge clock);
      check("alt_n2_valid", {30'd0, bus.p0_valid, bus.p1_valid}, 32'd1);
      check("alt_n2_q1", bus.p1_q, 32'h22);
      check("alt_n2_q0", bus.p0_q, 32'd0);
      next_cycle();

      // Continuous contention: p0 x4, p1 x1, with returns routed per grant
      drive0(1'b1, 1'b0, 12'h001, 32'd0);
      drive1(1'b1, 1'b0, 12'h002, 32'd0);
      for (int i = 0; i < 10; i++) begin
         logic exp1;
         logic prev1;
         exp1  = (i % 5 == 4);
         prev1 = (i % 5 == 0) && (i != 0);
         @(negedge clock);
         check($sformatf("cont_gnt_%0d", i), {30'd0, bus.p0_gnt, bus.p1_gnt}, {30'd0, !exp1, exp1});
         if (i > 0) begin
            check($sformatf("cont_valid_%0d", i), {30'd0, bus.p0_valid, bus.p1_valid}, {30'd0, !prev1, prev1});
            check($sformatf("cont_q_%0d", i), prev1 ? bus.p1_q : bus.p0_q, prev1 ? 32'h22 : 32'h11);
         end
         next_cycle();
      end
      drive1(1'b0, 1'b0, 12'h000, 32'd0);
      next_cycle();

      // p1 waits 3, drops for 1, re-requests: starve restarts from 0
      for (int j = 0; j < 3; j++) begin
         drive1(1'b1, 1'b0, 12'h002, 32'd0);
         @(negedge clock);
         check($sformatf("drop_wait_%0d", j), {30'd0, bus.p0_gnt, bus.p1_gnt}, 32'd2);
         next_cycle();
      end
      drive1(1'b0, 1'b0, 12'h000, 32'd0);
      @(negedge clock);
      check("drop_gap", {30'd0, bus.p0_gnt, bus.p1_gnt}, 32'd2);
      next_cycle();
      for (int j = 0; j < 5; j++) begin
         drive1(1'b1, 1'b0, 12'h002, 32'd0);
         @(negedge clock);
         check($sformatf("rereq_%0d", j), {30'd0, bus.p0_gnt, bus.p1_gnt}, (j == 4) ? 32'd1 : 32'd2);
         next_cycle();
      end
      drive0(1'b0, 1'b0, 12'h000, 32'd0);
      drive1(1'b0, 1'b0, 12'h000, 32'd0);
      next_cycle();

      // p0 read granted, then reset: no return, quiet during reset
      drive0(1'b1, 1'b0, 12'h001, 32'd0);
      @(negedge clock);
      check("prerst_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, 32'd2);
      next_cycle();
      reset = 1'b1;
      drive1(1'b1, 1'b0, 12'h002, 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         check_quiet($sformatf("midrst_%0d", k));
         next_cycle();
      end
      reset = 1'b0;
      @(negedge clock);
      check("postrst_gnt", {30'd0, bus.p0_gnt, bus.p1_gnt}, 32'd2);
      check("postrst_valid", {30'd0, bus.p0_valid, bus.p1_valid}, 32'd0);
      next_cycle();
      @(negedge clock);
      check("postrst_ret", {30'd0, bus.p0_valid, bus.p1_valid}, 32'd2);
      check("postrst_q", bus.p0_q, 32'h11);
      next_cycle();
      drive0(1'b0, 1'b0, 12'h000, 32'd0);
      drive1(1'b0, 1'b0, 12'h000, 32'd0);
      next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
